bit_derotator: RTL and testbench
================================

BIT_DEROTATOR -- requirements
Module: bit_derotator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits.
REQ-002 SHALL have parameter AMT_W, default 3, meaning rotate-amount width; AMT_W = log2(WIDTH).
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  rotated word offered.
REQ-006 SHALL have port in_ready  output  1  block can accept a word.
REQ-007 SHALL have port data_in  input  WIDTH  rotated word to be restored.
REQ-008 SHALL have port rot_amt  input  AMT_W  bit positions the word was rotated by.
REQ-009 SHALL have port rotate_dir  input  1  original rotation: 0 = left, 1 = right.
REQ-010 SHALL have port out_valid  output  1  restored word available.
REQ-011 SHALL have port out_ready  input  1  downstream accepts restored word.
REQ-012 SHALL have port data_out  output  WIDTH  restored original word, registered.
REQ-013 SHALL have port busy  output  1  high in SHIFT or HOLD.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, SHIFT, HOLD.
REQ-015 SHALL drive in_ready high only in IDLE and low in SHIFT and HOLD, with no overlap of input and output transfers.
REQ-016 SHALL accept at edge E0 when in_valid && in_ready, latching data_in, rot_amt and rotate_dir into internal registers.
REQ-017 SHALL go to HOLD at E0 if rot_amt == 0; otherwise SHALL go to SHIFT with counter = rot_amt.
REQ-018 In SHIFT, SHALL rotate the working register by one bit per edge opposite to the latched direction (rotate_dir=0 -> rotate right, 1 -> rotate left) and decrement the counter.
REQ-019 SHALL leave SHIFT for HOLD on the edge where the counter goes 1 -> 0, so out_valid rises at edge E0+rot_amt.
REQ-020 In HOLD, SHALL assert out_valid and present the working register on data_out.
REQ-021 While out_valid && !out_ready, data_out SHALL remain stable and in_valid SHALL be ignored.
REQ-022 On out_valid && out_ready, SHALL return to IDLE at that edge; the next acceptance SHALL occur no earlier than the following edge.
REQ-023 Rotation SHALL be modulo WIDTH with no bit lost; rot_amt = WIDTH-1 SHALL take WIDTH-1 shift cycles.
REQ-024 Input changes outside the acceptance edge SHALL have no effect on an in-flight word.

Reset
REQ-025 reset SHALL act immediately, regardless of clk, forcing IDLE and clearing counter, working register and direction.
REQ-026 During and after reset: in_ready=1 (once reset deasserts), out_valid=0, busy=0, data_out=0.
REQ-027 Reset asserted mid-SHIFT or mid-HOLD SHALL discard the word with no out_valid pulse.

Configuration
REQ-028 Macro DEROT_PARITY_EN SHALL, when defined, add input par_in (1, even-parity bit supplied with data_in) and output par_err (1).
REQ-029 With DEROT_PARITY_EN, par_err SHALL be registered at acceptance as (XOR of data_in) XOR par_in, be valid with out_valid, and reset to 0.
REQ-030 Without DEROT_PARITY_EN, par_in, par_err and all parity logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-031 SHALL cover: data_in=8'b01100111, rot_amt=1, rotate_dir=0 -> data_out=8'b10110011, out_valid at E0+1.
REQ-032 SHALL cover: data_in=8'b01110110, rot_amt=3, rotate_dir=1 -> data_out=8'b10110011, out_valid at E0+3, busy high E0..release.
REQ-033 SHALL cover: data_in=8'hA5, rot_amt=0 -> data_out=8'hA5, out_valid at E0.
REQ-034 SHALL cover: out_ready=0 for 5 cycles in HOLD while in_valid=1 with new data -> data_out stable, in_ready=0, new word not accepted until the edge after out_ready=1.
REQ-035 SHALL cover: reset pulsed at E0+2 with rot_amt=5 -> out_valid=0, data_out=0, busy=0 immediately, and no output word.
REQ-036 SHALL cover, with DEROT_PARITY_EN: data_in=8'hA5, par_in=1 -> par_err=1; par_in=0 -> par_err=0.

Source files
------------

// File: rtl/bit_derotator.sv
// Restores a word that was rotated by rot_amt in rotate_dir, one bit position per clock.
// Define DEROT_PARITY_EN to add the par_in input and the registered par_err output.
module bit_derotator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] rot_amt,
  input  logic             rotate_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             busy
`ifdef DEROT_PARITY_EN
  ,
  input  logic             par_in,
  output logic             par_err
`endif
);

  typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

  state_e           state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             dir_q, dir_d;
  logic             accept;

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    dir_d     = dir_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = !reset;
        if (in_valid && !reset) begin
          work_d  = data_in;
          dir_d   = rotate_dir;
          cnt_d   = rot_amt;
          state_d = (rot_amt == '0) ? StHold : StShift;
        end
      end
      StShift: begin
        // Undo the original rotation: left-rotated words go right, and vice versa.
        if (dir_q) work_d = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
        else       work_d = {work_q[0], work_q[WIDTH-1:1]};
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) state_d = StHold;
      end
      StHold: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      work_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      dir_q   <= dir_d;
    end
  end

  assign data_out = work_q;
  assign busy     = (state_q != StIdle);

`ifdef DEROT_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_err_q <= 1'b0;
    end else if (accept) begin
      par_err_q <= (^data_in) ^ par_in;
    end
  end

  assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_bit_derotator.sv
// Scoreboard bench for bit_derotator: driver pushes expected words, a negedge monitor
// pops and compares each word the DUT hands off.
module tb_bit_derotator;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_in;
  logic [2:0] rot_amt;
  logic       rotate_dir;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] data_out;
  logic       busy;
`ifdef DEROT_PARITY_EN
  logic       par_in;
  logic       par_err;
`endif

  typedef struct {
    logic [7:0] data;
    logic       perr;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  bit_derotator #(.WIDTH(8), .AMT_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .rot_amt   (rot_amt),
    .rotate_dir(rotate_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
`ifdef DEROT_PARITY_EN
    ,
    .par_in    (par_in),
    .par_err   (par_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every handshake on the output side must match the oldest expected word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_output: got %h, required no word (t=%0t)", data_out, $time);
        end else begin
          e = sb.pop_front();
          chk("data_out", data_out, e.data);
`ifdef DEROT_PARITY_EN
          chk("par_err", {7'd0, par_err}, {7'd0, e.perr});
`endif
        end
      end
    end
  end

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 after out_valid
  // rises (or right after acceptance when wait_out is 0).
  task automatic send(input logic [7:0] d, input logic [2:0] amt, input logic dir,
                      input logic [7:0] exp, input logic par, input bit push,
                      input bit wait_out);
    int   lat;
    exp_t e;
    lat = 0;
    while (in_ready !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready !== 1'b1) chk("in_ready_timeout", {7'd0, in_ready}, 8'd1);
    in_valid   = 1'b1;
    data_in    = d;
    rot_amt    = amt;
    rotate_dir = dir;
`ifdef DEROT_PARITY_EN
    par_in     = par;
`endif
    e.data = exp;
    e.perr = (^d) ^ par;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the in-flight word must not notice.
    in_valid   = 1'b0;
    data_in    = ~d;
    rot_amt    = ~amt;
    rotate_dir = ~dir;
    chk("busy_after_accept", {7'd0, busy}, 8'd1);
    if (!wait_out) return;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      chk("busy_in_shift", {7'd0, busy}, 8'd1);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 8'(lat), {5'd0, amt});
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    data_in    = 8'h00;
    rot_amt    = 3'd0;
    rotate_dir = 1'b0;
    out_ready  = 1'b1;
`ifdef DEROT_PARITY_EN
    par_in     = 1'b0;
`endif
    #1;
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_data_out", data_out, 8'h00);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", {7'd0, in_ready}, 8'd1);

    // Directed vectors: data, amount, direction, expected restored word.
    send(8'b01100111, 3'd1, 1'b0, 8'b10110011, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    send(8'b01110110, 3'd3, 1'b1, 8'b10110011, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    send(8'hA5, 3'd0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    send(8'hA5, 3'd0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    send(8'h81, 3'd7, 1'b0, 8'h03, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    send(8'h81, 3'd7, 1'b1, 8'hC0, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;

    // Backpressure in HOLD with a new word waiting on the input.
    out_ready = 1'b0;
    send(8'hF0, 3'd4, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b1);
    in_valid   = 1'b1;
    data_in    = 8'h3C;
    rot_amt    = 3'd2;
    rotate_dir = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold_data_out", data_out, 8'h0F);
      chk("hold_in_ready", {7'd0, in_ready}, 8'd0);
      chk("hold_out_valid", {7'd0, out_valid}, 8'd1);
    end
    begin
      exp_t e;
      e.data = 8'h0F;
      e.perr = (^8'h3C) ^ 1'b0;
      sb.push_back(e);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_busy", {7'd0, busy}, 8'd0);
    chk("release_in_ready", {7'd0, in_ready}, 8'd1);
    @(posedge clk); #1;
    chk("next_accept_busy", {7'd0, busy}, 8'd1);
    in_valid = 1'b0;
    data_in  = 8'hFF;
    @(posedge clk); #1;
    chk("next_word_shift", {7'd0, out_valid}, 8'd0);
    @(posedge clk); #1;
    chk("next_word_valid", {7'd0, out_valid}, 8'd1);
    @(posedge clk); #1;

    // Reset two edges into a five-step shift: the word must vanish.
    send(8'h5A, 3'd5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("midrst_data_out", data_out, 8'h00);
    chk("midrst_busy", {7'd0, busy}, 8'd0);
    @(posedge clk); #3;
    reset = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) chk("midrst_no_output", {7'd0, out_valid}, 8'd0);
    end
    chk("midrst_in_ready", {7'd0, in_ready}, 8'd1);
    chk("scoreboard_empty", 8'(sb.size()), 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
